// File: rtl/best_report_tx.sv
// best_report_tx: snapshots the best nonce/score and sends it as a
// 36-byte 8N1 UART frame (sync, score, nonce, XOR checksum).
module best_report_tx #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic         clk_i,
    input  logic         reset_i,
    input  logic [255:0] best_nonce_i,
    input  logic [9:0]   best_bits_off_i,
    input  logic         report_tick_i,
    output logic         tx_o,
    output logic         busy_o,
    output logic         clear_best_o
);

    localparam int            BW        = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [5:0]    LAST_BYTE = 6'd35;
    localparam logic [7:0]    SYNC      = 8'hA5;

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_e;

    state_e         state_q, state_d;
    logic [BW-1:0]  baud_q, baud_d;
    logic [2:0]     bit_q, bit_d;
    logic [5:0]     byte_q, byte_d;
    logic [7:0]     cur_q, cur_d;
    logic [7:0]     csum_q, csum_d;
    logic [255:0]   nonce_q, nonce_d;
    logic [9:0]     bits_q, bits_d;
    logic           tx_q, tx_d;
    logic           busy_q, busy_d;
    logic           clear_q, clear_d;

    logic           accept;
    logic           bit_end;
    logic [5:0]     next_idx;
    logic [7:0]     next_byte;

    assign accept   = (state_q == S_IDLE) && report_tick_i &&
                      (best_bits_off_i != 10'h3FF);
    assign bit_end  = (state_q != S_IDLE) && (baud_q == BAUD_LAST);
    assign next_idx = byte_q + 6'd1;

    assign tx_o         = tx_q;
    assign busy_o       = busy_q;
    assign clear_best_o = clear_q;

    // State register and registered outputs
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= S_IDLE;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            clear_q <= 1'b0;
        end else begin
            state_q <= state_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            clear_q <= clear_d;
        end
    end

    // Next-state logic: start/data/stop per byte, 36 bytes per frame
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (accept) state_d = S_START;
            end
            S_START: begin
                if (bit_end) state_d = S_DATA;
            end
            S_DATA: begin
                if (bit_end && (bit_q == 3'd7)) state_d = S_STOP;
            end
            S_STOP: begin
                if (bit_end) begin
                    state_d = (byte_q == LAST_BYTE) ? S_IDLE : S_START;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output logic: outputs are registered, so decode from next state
    always_comb begin
        busy_d  = (state_d != S_IDLE);
        clear_d = accept;
        unique case (state_d)
            S_START: tx_d = 1'b0;
            S_DATA:  tx_d = cur_d[bit_d];
            default: tx_d = 1'b1;
        endcase
    end

    // Select the byte that follows the current one in the frame
    always_comb begin
        next_byte = nonce_q[255:248];
        if (next_idx == 6'd1) begin
            next_byte = {6'b0, bits_q[9:8]};
        end else if (next_idx == 6'd2) begin
            next_byte = bits_q[7:0];
        end else if (next_idx == LAST_BYTE) begin
            next_byte = csum_q;
        end
    end

    // Datapath next-state: counters, snapshot, byte loader, checksum
    always_comb begin
        baud_d  = baud_q;
        bit_d   = bit_q;
        byte_d  = byte_q;
        cur_d   = cur_q;
        csum_d  = csum_q;
        nonce_d = nonce_q;
        bits_d  = bits_q;
        if (accept) begin
            nonce_d = best_nonce_i;
            bits_d  = best_bits_off_i;
            byte_d  = 6'd0;
            cur_d   = SYNC;
            csum_d  = 8'h00;
            bit_d   = 3'd0;
            baud_d  = '0;
        end else if (state_q != S_IDLE) begin
            baud_d = bit_end ? '0 : baud_q + BW'(1);
            if (bit_end && (state_q == S_DATA)) begin
                bit_d = bit_q + 3'd1;
            end
            if (bit_end && (state_q == S_STOP) && (byte_q != LAST_BYTE)) begin
                byte_d = next_idx;
                cur_d  = next_byte;
                if (next_idx != LAST_BYTE) begin
                    csum_d = csum_q ^ next_byte;
                end
                // Nonce is consumed MSB byte first by shifting the snapshot
                if ((next_idx >= 6'd3) && (next_idx < LAST_BYTE)) begin
                    nonce_d = {nonce_q[247:0], 8'h00};
                end
            end
        end
    end

    // Datapath registers
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            baud_q  <= '0;
            bit_q   <= 3'd0;
            byte_q  <= 6'd0;
            cur_q   <= 8'h00;
            csum_q  <= 8'h00;
            nonce_q <= '0;
            bits_q  <= 10'd0;
        end else begin
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            byte_q  <= byte_d;
            cur_q   <= cur_d;
            csum_q  <= csum_d;
            nonce_q <= nonce_d;
            bits_q  <= bits_d;
        end
    end

endmodule

// File: tb/tb_best_report_tx.sv
// tb_best_report_tx: scoreboarded UART frame checks for best_report_tx
// with a mid-bit sampling serial monitor.
module tb_best_report_tx;

    localparam int C = 4;
    localparam int H = C / 2;
    localparam int FRAME = 360 * C;

    logic         clk;
    logic         rst;
    logic [255:0] nonce;
    logic [9:0]   bits;
    logic         tick;
    logic         tx;
    logic         busy;
    logic         clr;

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;
    int n_busy = 0;
    int n_clr  = 0;
    int n_low  = 0;
    int n_rx   = 0;

    logic [7:0] exp_q[$];

    int  m_cnt = 0;
    logic m_act = 1'b0;
    logic [7:0] m_sh = 8'h00;

    best_report_tx #(.CLKS_PER_BIT(C)) dut (
        .clk_i           (clk),
        .reset_i         (rst),
        .best_nonce_i    (nonce),
        .best_bits_off_i (bits),
        .report_tick_i   (tick),
        .tx_o            (tx),
        .busy_o          (busy),
        .clear_best_o    (clr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Cycle counter
    always @(posedge clk) cyc <= cyc + 1;

    // Activity counters for busy cycles, clear pulses, low tx cycles
    always @(negedge clk) begin
        if (!rst) begin
            n_busy <= n_busy + int'(busy);
            n_clr  <= n_clr + int'(clr);
            n_low  <= n_low + int'(!tx);
        end
    end

    // UART monitor: decode each byte mid-bit and compare to scoreboard
    always @(negedge clk) begin
        logic [7:0] e;
        if (rst) begin
            m_act <= 1'b0;
            m_cnt <= 0;
        end else if (!m_act) begin
            if (!tx) begin
                m_act <= 1'b1;
                m_cnt <= 1;
            end
        end else begin
            m_cnt <= m_cnt + 1;
            if (m_cnt == H) begin
                check("rx_start", {31'd0, tx}, 32'd0);
            end
            if ((m_cnt >= C + H) && (m_cnt <= 8 * C + H) &&
                ((m_cnt - H) % C == 0)) begin
                m_sh <= {tx, m_sh[7:1]};
            end
            if (m_cnt == 9 * C + H) begin
                check("rx_stop", {31'd0, tx}, 32'd1);
                n_rx  <= n_rx + 1;
                m_act <= 1'b0;
                if (exp_q.size() == 0) begin
                    check("rx_extra", {24'd0, m_sh}, 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    check("rx_byte", {24'd0, m_sh}, {24'd0, e});
                end
            end
        end
    end

    task automatic push_frame(input logic [255:0] n, input logic [9:0] b);
        logic [7:0] cs;
        logic [7:0] v;
        cs = 8'h00;
        exp_q.push_back(8'hA5);
        v = {6'b0, b[9:8]};
        exp_q.push_back(v);
        cs = cs ^ v;
        v = b[7:0];
        exp_q.push_back(v);
        cs = cs ^ v;
        for (int i = 0; i < 32; i++) begin
            v = n[255 - 8 * i -: 8];
            exp_q.push_back(v);
            cs = cs ^ v;
        end
        exp_q.push_back(cs);
    endtask

    task automatic launch();
        @(posedge clk);
        #1 tick = 1'b1;
        @(posedge clk);
        #1 tick = 1'b0;
    endtask

    task automatic wait_busy(input logic lvl, input int lim,
                             input string tag);
        int n;
        n = 0;
        while ((busy !== lvl) && (n < lim)) begin
            @(negedge clk);
            n++;
        end
        if (busy !== lvl) check(tag, {31'd0, busy}, {31'd0, lvl});
    endtask

    task automatic frame_done(input string tag, input int b0,
                              input int c0, input int r0);
        wait_busy(1'b0, FRAME + 100, {tag, "_timeout"});
        repeat (5) @(negedge clk);
        check({tag, "_busy"}, n_busy - b0, FRAME);
        check({tag, "_clr"}, n_clr - c0, 1);
        check({tag, "_nrx"}, n_rx - r0, 36);
        check({tag, "_qleft"}, exp_q.size(), 0);
    endtask

    function automatic logic [255:0] rnd_nonce();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[32 * i +: 32] = $urandom();
        return r;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [255:0] nonce3;
        int b0;
        int c0;
        int r0;
        int l0;
        int rise [3];
        int fall [3];

        for (int i = 0; i < 32; i++) nonce3[255 - 8 * i -: 8] = 8'(i);

        rst   = 1'b1;
        tick  = 1'b0;
        nonce = '0;
        bits  = 10'h3FF;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_tx", {31'd0, tx}, 32'd1);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_clr", {31'd0, clr}, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Idle line for 100 cycles
        b0 = n_busy; c0 = n_clr; l0 = n_low;
        repeat (100) @(negedge clk);
        check("idle_busy", n_busy - b0, 0);
        check("idle_clr", n_clr - c0, 0);
        check("idle_low", n_low - l0, 0);

        // No result yet: ticks ignored
        b0 = n_busy; c0 = n_clr; l0 = n_low; r0 = n_rx;
        @(posedge clk);
        #1 tick = 1'b1;
        repeat (5) @(posedge clk);
        #1 tick = 1'b0;
        repeat (2000) @(negedge clk);
        check("nores_busy", n_busy - b0, 0);
        check("nores_clr", n_clr - c0, 0);
        check("nores_low", n_low - l0, 0);
        check("nores_rx", n_rx - r0, 0);

        // Known frame
        nonce = nonce3;
        bits  = 10'h17B;
        push_frame(nonce3, 10'h17B);
        b0 = n_busy; c0 = n_clr; r0 = n_rx;
        launch();
        @(negedge clk);
        check("t3_clr_n1", {31'd0, clr}, 32'd1);
        check("t3_busy_n1", {31'd0, busy}, 32'd1);
        check("t3_tx_n1", {31'd0, tx}, 32'd0);
        @(negedge clk);
        check("t3_clr_n2", {31'd0, clr}, 32'd0);
        frame_done("t3", b0, c0, r0);

        // Same frame while inputs churn and ticks repeat mid-frame
        push_frame(nonce3, 10'h17B);
        b0 = n_busy; c0 = n_clr; r0 = n_rx;
        launch();
        for (int i = 0; i < FRAME - 140; i++) begin
            @(posedge clk);
            #1;
            nonce = rnd_nonce();
            bits  = 10'($urandom_range(0, 1023));
            tick  = 1'($urandom_range(0, 1));
        end
        tick = 1'b0;
        frame_done("t4", b0, c0, r0);
        b0 = n_busy;
        repeat (50) @(negedge clk);
        check("t4_noframe", n_busy - b0, 0);

        // Reset during byte 10
        nonce = rnd_nonce();
        bits  = 10'($urandom_range(0, 1022));
        push_frame(nonce, bits);
        c0 = n_clr; r0 = n_rx;
        launch();
        repeat (10 * 10 * C) @(posedge clk);
        #2;
        check("t5_pre_tx", {31'd0, tx}, 32'd0);
        check("t5_partial", n_rx - r0, 10);
        #1 rst = 1'b1;
        #1;
        check("t5_rst_tx", {31'd0, tx}, 32'd1);
        check("t5_rst_busy", {31'd0, busy}, 32'd0);
        check("t5_rst_clr", {31'd0, clr}, 32'd0);
        exp_q.delete();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        b0 = n_busy;
        repeat (20) @(negedge clk);
        check("t5_noresume", n_busy - b0, 0);
        check("t5_noclr", n_clr - c0, 1);
        nonce = rnd_nonce();
        bits  = 10'($urandom_range(0, 1022));
        push_frame(nonce, bits);
        b0 = n_busy; c0 = n_clr; r0 = n_rx;
        launch();
        frame_done("t5", b0, c0, r0);

        // Tick held high: back-to-back frames with one idle cycle
        nonce = rnd_nonce();
        bits  = 10'h000;
        for (int k = 0; k < 3; k++) push_frame(nonce, bits);
        c0 = n_clr; r0 = n_rx;
        @(posedge clk);
        #1 tick = 1'b1;
        for (int k = 0; k < 3; k++) begin
            wait_busy(1'b1, 100, "t6_rise_timeout");
            rise[k] = cyc;
            if (k == 2) tick = 1'b0;
            wait_busy(1'b0, FRAME + 100, "t6_fall_timeout");
            fall[k] = cyc;
        end
        for (int k = 0; k < 3; k++) begin
            check("t6_len", fall[k] - rise[k], FRAME);
        end
        for (int k = 0; k < 2; k++) begin
            check("t6_gap", rise[k + 1] - fall[k], 1);
        end
        b0 = n_busy;
        repeat (50) @(negedge clk);
        check("t6_stop", n_busy - b0, 0);
        check("t6_clr", n_clr - c0, 3);
        check("t6_nrx", n_rx - r0, 108);
        check("t6_qleft", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/best_report_tx.md
# best_report_tx

Serializes the current best search result (nonce plus bits-off score) from `hash_best` into a fixed 36-byte UART frame on a single serial line. It sits between `hash_best` and the chip's serial pin. On a report request it snapshots the best result and pulses `clear_best_o` (wired to `hash_best.reset_i`) so a new search window starts. It then transmits the snapshot 8N1, LSB-first.

## Interface

Parameters:
- `CLKS_PER_BIT`, default 434 — clock cycles per UART bit (50 MHz / 115200); legal range ≥ 2.

Ports:
- `clk_i`  input  1  — single clock; all logic on rising edge.
- `reset_i`  input  1  — asynchronous, active-high reset.
- `best_nonce_i`  input  256  — best nonce from `hash_best`.
- `best_bits_off_i`  input  10  — best score from `hash_best`; 10'h3FF means no result yet.
- `report_tick_i`  input  1  — report request, level-sampled each cycle.
- `tx_o`  output  1  — UART serial out, idle high.
- `busy_o`  output  1  — high while a frame is in flight.
- `clear_best_o`  output  1  — one-cycle pulse; drives `hash_best.reset_i`.

## Operation

- States: IDLE, START, DATA, STOP. Counters: baud counter 0..CLKS_PER_BIT-1, bit index 0..7, byte index 0..35.
- IDLE with `report_tick_i`=1 and `best_bits_off_i` != 10'h3FF:
  - latch nonce and bits-off into snapshot registers;
  - byte index ← 0; go to START.
- IDLE with tick=1 and bits-off = 10'h3FF: tick ignored, stay IDLE, no clear pulse.
- Ticks are ignored outside IDLE and are never queued.
- Snapshot registers are frozen for the whole frame; input changes mid-frame do not affect it.
- Frame byte order:
  - byte 0 = 8'hA5;
  - byte 1 = {6'b0, bits_off[9:8]};
  - byte 2 = bits_off[7:0];
  - bytes 3..34 = nonce[255:248] down to nonce[7:0];
  - byte 35 = XOR of bytes 1..34.
- Checksum accumulates as bytes are loaded; it does not include the sync byte.
- Per byte:
  - START drives 0 for CLKS_PER_BIT cycles;
  - DATA drives bits 0..7 (LSB first), each for CLKS_PER_BIT cycles;
  - STOP drives 1 for CLKS_PER_BIT cycles.
- After STOP: byte index < 35 → increment and go to START (no inter-byte gap); byte index = 35 → go to IDLE.
- `tx_o` is registered; 1 in IDLE and STOP.
- `clear_best_o` pulses exactly once per accepted tick, in the cycle after acceptance. `hash_best` then restarts its search window while this frame transmits. A hash arriving at `hash_best` in that same cycle is lost, because `hash_best` gives its reset priority over a new hash.

## Timing

- Reset values: `tx_o`=1, `busy_o`=0, `clear_best_o`=0, state IDLE, counters 0, snapshot 0.
- Reset mid-frame: outputs take their reset values immediately (asynchronous). The frame is aborted and nothing resumes after reset release.
- Tick accepted in cycle N:
  - `clear_best_o`=1 only in cycle N+1;
  - `busy_o` and start bit (`tx_o`=0) from cycle N+1.
- Frame length: exactly 36 × 10 × CLKS_PER_BIT cycles. `busy_o` falls in cycle N+1+360·CLKS_PER_BIT, and that cycle is back in IDLE.
- A tick present in the cycle `busy_o` falls is accepted. A tick held high continuously therefore gives frames separated by exactly one idle-high cycle.
- Bit-boundary jitter: none. Every bit lasts exactly CLKS_PER_BIT cycles.

## Test plan

Use CLKS_PER_BIT=4 and a bench UART monitor sampling mid-bit.

1. Reset asserted and released with tick=0 → `tx_o`=1, `busy_o`=0, `clear_best_o`=0 for 100 cycles. Reset asserted asynchronously mid-cycle → outputs change before the next edge.
2. `best_bits_off_i`=10'h3FF, tick pulsed → no `busy_o`, no `clear_best_o`, `tx_o` stays 1 for 2000 cycles.
3. bits_off=10'h17B, nonce bytes 8'h00..8'h1F (MSB byte 8'h00), tick in cycle N:
   - monitor decodes A5, 01, 7B, 00..1F, 7A;
   - `clear_best_o` high only in cycle N+1;
   - `busy_o` high for exactly 1440 cycles.
4. During the frame from test 3, change both inputs every cycle and pulse tick repeatedly → decoded bytes are identical to test 3. Exactly one clear pulse and one frame.
5. Assert `reset_i` during byte 10 → `tx_o`=1 and `busy_o`=0 immediately, no clear pulse. Then a new tick → a complete, correct 36-byte frame.
6. Hold tick high with bits_off=10'h000 → consecutive frames, each 1440 busy cycles, one idle cycle between frames, one clear pulse per frame.
